uart_cmd_rx: RTL and testbench

- Receives ASCII command lines from the host over the UART RX pin (host→FPGA; the opposite direction to the phase/frequency report stream) and applies them as control registers for the 1PPS generator.
- Contains a byte-level UART receiver and a line parser that decode sync-enable and PPS-offset commands.
- Sits in the 50 MHz domain next to the report transmitter; its outputs drive the PPS generator's sync-enable input and its phase-offset input.

---
 rtl/pps_pkg.sv | 29 ++
 rtl/uart_rx_byte.sv | 80 ++++++++
 rtl/uart_cmd_rx.sv | 136 +++++++++++++
 tb/tb_uart_cmd_rx.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/pps_pkg.sv
// Shared constants and encodings for the 1PPS control path.
// Includes the UART timing default, ASCII codes, FSM states and character helpers.
package pps_pkg;
  localparam int unsigned CLK_HZ            = 50_000_000;
  localparam int unsigned BAUD              = 115_200;
  localparam int unsigned CLKS_PER_BIT_DFLT = (CLK_HZ + BAUD / 2) / BAUD;

  localparam logic [7:0] CHR_S  = 8'h53;
  localparam logic [7:0] CHR_O  = 8'h4F;
  localparam logic [7:0] CHR_CR = 8'h0D;
  localparam logic [7:0] CHR_LF = 8'h0A;
  localparam logic [7:0] CHR_0  = 8'h30;
  localparam logic [7:0] CHR_1  = 8'h31;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {P_IDLE, P_GOT_S, P_GOT_O, P_WAIT_EOL, P_DISCARD} prs_state_t;

  function automatic logic is_eol(input logic [7:0] c);
    return (c == CHR_CR) || (c == CHR_LF);
  endfunction

  // Returns {valid, nibble}.
  function automatic logic [4:0] hex_nib(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39)      return {1'b1, c[3:0]};
    else if (c >= 8'h41 && c <= 8'h46) return {1'b1, c[3:0] + 4'd9};
    else if (c >= 8'h61 && c <= 8'h66) return {1'b1, c[3:0] + 4'd9};
    else                               return 5'b0;
  endfunction
endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: two-flop synchronizer, mid-bit sampling.
// A framing error drops the byte; the FSM returns to idle at mid-stop so frames may abut.
module uart_rx_byte
  import pps_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DFLT
) (
  input  logic       i_clk,
  input  logic       i_res_n,
  input  logic       i_rx,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  output logic       o_frame_err
);
  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]       r_sync;
  logic             w_rx;
  rx_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit;
  logic [7:0]       r_shreg;
  logic             w_half, w_full;

  assign w_rx      = r_sync[1];
  assign w_half    = (r_cnt == HALF);
  assign w_full    = (r_cnt == FULL);
  assign o_rx_data = r_shreg;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RX_IDLE:  if (!w_rx) w_state_nxt = RX_START;
      RX_START: if (w_half) w_state_nxt = w_rx ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_full && r_bit == 3'd7) w_state_nxt = RX_STOP;
      RX_STOP:  if (w_full) w_state_nxt = RX_IDLE;
      default:  w_state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      r_sync      <= 2'b11;
      r_state     <= RX_IDLE;
      r_cnt       <= '0;
      r_bit       <= '0;
      r_shreg     <= '0;
      o_rx_valid  <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      r_sync      <= {r_sync[0], i_rx};
      r_state     <= w_state_nxt;
      o_rx_valid  <= 1'b0;
      o_frame_err <= 1'b0;
      case (r_state)
        RX_START: begin
          r_cnt <= w_half ? '0 : r_cnt + 1'b1;
          r_bit <= '0;
        end
        RX_DATA: begin
          if (w_full) begin
            r_cnt   <= '0;
            r_shreg <= {w_rx, r_shreg[7:1]};
            r_bit   <= r_bit + 1'b1;
          end else r_cnt <= r_cnt + 1'b1;
        end
        RX_STOP: begin
          if (w_full) begin
            r_cnt       <= '0;
            o_rx_valid  <= w_rx;
            o_frame_err <= !w_rx;
          end else r_cnt <= r_cnt + 1'b1;
        end
        default: r_cnt <= '0;
      endcase
    end
  end
endmodule

// File: rtl/uart_cmd_rx.sv
// Host command receiver: "S0"/"S1" sets PPS sync enable, "Ohhhhhhhh" loads the PPS offset.
// Lines end in CR or LF; malformed lines and framing errors pulse o_cmd_err once per line.
module uart_cmd_rx
  import pps_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DFLT,
  parameter int unsigned OFS_W        = 32
) (
  input  logic             i_clk,
  input  logic             i_res_n,
  input  logic             i_uart_rx,
  output logic             o_pps_sync_en,
  output logic [OFS_W-1:0] o_pps_offset,
  output logic             o_offset_upd,
  output logic             o_cmd_err,
  output logic [7:0]       o_err_cnt
);
  logic [7:0] w_rx_data;
  logic       w_rx_valid, w_frame_err;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .i_clk       (i_clk),
    .i_res_n     (i_res_n),
    .i_rx        (i_uart_rx),
    .o_rx_data   (w_rx_data),
    .o_rx_valid  (w_rx_valid),
    .o_frame_err (w_frame_err)
  );

  prs_state_t  r_state, w_state_nxt;
  logic [31:0] r_shreg;
  logic [3:0]  r_dcnt;
  logic        r_is_o, r_pend_s, r_err_sent;
  logic        w_eol;
  logic [4:0]  w_hex;
  logic        w_commit_s, w_commit_o, w_err, w_clr, w_shift, w_load_s, w_mark;

  assign w_eol = is_eol(w_rx_data);
  assign w_hex = hex_nib(w_rx_data);

  always_comb begin
    w_state_nxt = r_state;
    w_commit_s  = 1'b0;
    w_commit_o  = 1'b0;
    w_err       = 1'b0;
    w_clr       = 1'b0;
    w_shift     = 1'b0;
    w_load_s    = 1'b0;
    w_mark      = 1'b0;
    if (w_frame_err) begin
      w_err = 1'b1;
      if (r_state != P_IDLE) begin
        w_state_nxt = P_DISCARD;
        w_mark      = 1'b1;
      end
    end else if (w_rx_valid) begin
      case (r_state)
        P_IDLE: begin
          if (w_eol) w_state_nxt = P_IDLE;
          else if (w_rx_data == CHR_S) w_state_nxt = P_GOT_S;
          else if (w_rx_data == CHR_O) begin
            w_state_nxt = P_GOT_O;
            w_clr       = 1'b1;
          end else w_state_nxt = P_DISCARD;
        end
        P_GOT_S: begin
          if (w_rx_data == CHR_0 || w_rx_data == CHR_1) begin
            w_state_nxt = P_WAIT_EOL;
            w_load_s    = 1'b1;
          end else w_state_nxt = P_DISCARD;
        end
        P_GOT_O: begin
          if (w_hex[4]) begin
            w_shift = 1'b1;
            if (r_dcnt == 4'd7) w_state_nxt = P_WAIT_EOL;
          end else if (w_eol) begin
            w_err       = 1'b1;
            w_state_nxt = P_IDLE;
          end else w_state_nxt = P_DISCARD;
        end
        P_WAIT_EOL: begin
          if (w_eol) begin
            w_commit_s  = !r_is_o;
            w_commit_o  = r_is_o;
            w_state_nxt = P_IDLE;
          end else w_state_nxt = P_DISCARD;
        end
        P_DISCARD: begin
          // A line already reported by a framing error is not reported again at its EOL.
          if (w_eol) begin
            w_err       = !r_err_sent;
            w_state_nxt = P_IDLE;
          end
        end
        default: w_state_nxt = P_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      r_state       <= P_IDLE;
      r_shreg       <= '0;
      r_dcnt        <= '0;
      r_is_o        <= 1'b0;
      r_pend_s      <= 1'b0;
      r_err_sent    <= 1'b0;
      o_pps_sync_en <= 1'b0;
      o_pps_offset  <= '0;
      o_offset_upd  <= 1'b0;
      o_cmd_err     <= 1'b0;
      o_err_cnt     <= '0;
    end else begin
      r_state      <= w_state_nxt;
      o_offset_upd <= w_commit_o;
      o_cmd_err    <= w_err;
      if (w_err && o_err_cnt != 8'hFF) o_err_cnt <= o_err_cnt + 1'b1;
      if (w_commit_s) o_pps_sync_en <= r_pend_s;
      if (w_commit_o) o_pps_offset <= r_shreg[OFS_W-1:0];
      if (w_mark) r_err_sent <= 1'b1;
      else if (r_state == P_IDLE) r_err_sent <= 1'b0;
      if (w_clr) begin
        r_shreg <= '0;
        r_dcnt  <= '0;
        r_is_o  <= 1'b1;
      end else if (w_shift) begin
        r_shreg <= {r_shreg[27:0], w_hex[3:0]};
        r_dcnt  <= r_dcnt + 1'b1;
      end
      if (w_load_s) begin
        r_pend_s <= w_rx_data[0];
        r_is_o   <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_cmd_rx.sv
// Scoreboard bench for uart_cmd_rx: expected events queued at stimulus time,
// a negedge monitor pops and compares whenever sync_en changes, an offset loads or an error pulses.
module tb_uart_cmd_rx;
  localparam int CPB = 8;
  localparam logic [1:0] K_SYNC = 2'd0, K_OFS = 2'd1, K_ERR = 2'd2;

  typedef struct packed {
    logic [1:0]  k;
    logic [31:0] v;
  } exp_t;

  logic        clk = 1'b0, res_n = 1'b0, rx = 1'b1;
  logic        o_pps_sync_en, o_offset_upd, o_cmd_err;
  logic [31:0] o_pps_offset;
  logic [7:0]  o_err_cnt;

  exp_t q[$];
  int   n_vec = 0, n_mis = 0, model_cnt = 0, cyc = 0, last_sync_cyc = 0;

  uart_cmd_rx #(.CLKS_PER_BIT(CPB), .OFS_W(32)) dut (
    .i_clk         (clk),
    .i_res_n       (res_n),
    .i_uart_rx     (rx),
    .o_pps_sync_en (o_pps_sync_en),
    .o_pps_offset  (o_pps_offset),
    .o_offset_upd  (o_offset_upd),
    .o_cmd_err     (o_cmd_err),
    .o_err_cnt     (o_err_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] k, input logic [31:0] v);
    exp_t e;
    e.k = k;
    e.v = v;
    q.push_back(e);
  endtask

  task automatic pop(input logic [1:0] k, input logic [31:0] v, input string nm);
    exp_t e;
    n_vec++;
    if (q.size() == 0) begin
      n_mis++;
      $display("FAIL %s: unexpected event kind %0d value 0x%08h", nm, k, v);
    end else begin
      e = q.pop_front();
      if (e.k != k || (k != K_ERR && v !== e.v)) begin
        n_mis++;
        $display("FAIL %s: got kind %0d value 0x%08h, expected kind %0d value 0x%08h",
                 nm, k, v, e.k, e.v);
      end
    end
  endtask

  initial begin : monitor
    logic        ps, pu, pe;
    logic [31:0] po;
    ps = 0; pu = 0; pe = 0; po = 0;
    forever begin
      @(negedge clk);
      if (!res_n) begin
        ps = 0; pu = 0; pe = 0; po = 0;
        model_cnt = 0;
      end else begin
        if (o_pps_sync_en !== ps) begin
          pop(K_SYNC, {31'b0, o_pps_sync_en}, "sync_en");
          last_sync_cyc = cyc;
        end
        if (o_offset_upd) begin
          chk("upd_width", {31'b0, pu}, 32'd0);
          pop(K_OFS, o_pps_offset, "offset");
        end else if (o_pps_offset !== po) chk("offset_no_upd", o_pps_offset, po);
        if (o_cmd_err) begin
          chk("err_width", {31'b0, pe}, 32'd0);
          pop(K_ERR, 32'd0, "cmd_err");
          if (model_cnt < 255) model_cnt++;
          chk("err_cnt", {24'b0, o_err_cnt}, model_cnt);
        end
        ps = o_pps_sync_en; pu = o_offset_upd; pe = o_cmd_err; po = o_pps_offset;
      end
    end
  end

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  task automatic send_line(input string s, output int t_last);
    t_last = cyc;
    for (int i = 0; i < s.len(); i++) begin
      t_last = cyc;
      send_byte(s[i]);
    end
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (q.size() != 0 && n < 40 * CPB) begin
      @(posedge clk);
      n++;
    end
    #1;
    idle(2 * CPB);
    chk({nm, "_drained"}, q.size(), 32'd0);
    q.delete();
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_sync"}, {31'b0, o_pps_sync_en}, 32'd0);
    chk({nm, "_ofs"}, o_pps_offset, 32'd0);
    chk({nm, "_upd"}, {31'b0, o_offset_upd}, 32'd0);
    chk({nm, "_err"}, {31'b0, o_cmd_err}, 32'd0);
    chk({nm, "_cnt"}, {24'b0, o_err_cnt}, 32'd0);
  endtask

  initial begin : stim
    int t, d;
    repeat (4) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    res_n = 1'b1;
    idle(2 * CPB);

    // Sync enable on with latency window, then off via LF.
    push(K_SYNC, 32'd1);
    send_line("S1\r", t);
    drain("s1");
    d = last_sync_cyc - t;
    n_vec++;
    if (d < 9 * CPB + CPB / 2 || d > 10 * CPB + 2) begin
      n_mis++;
      $display("FAIL s1_latency: got %0d cycles from CR start, expected %0d..%0d",
               d, 9 * CPB + CPB / 2, 10 * CPB + 2);
    end
    push(K_SYNC, 32'd0);
    send_line("S0\n", t);
    drain("s0");

    push(K_OFS, 32'h0000ABCD);
    send_line("O0000ABCD\r", t);
    drain("ofs_abcd");
    push(K_OFS, 32'hFFFFFF9C);
    send_line("OFFFFFF9C\r\n", t);
    drain("ofs_m100");

    // Three rejected lines.
    repeat (3) push(K_ERR, 32'd0);
    send_line("O12G4\r", t);
    send_line("O123\r", t);
    send_line("S1x\r", t);
    drain("bad3");
    chk("bad3_cnt", {24'b0, o_err_cnt}, 32'd3);
    chk("bad3_ofs", o_pps_offset, 32'hFFFFFF9C);
    chk("bad3_sync", {31'b0, o_pps_sync_en}, 32'd0);

    // Framing error inside an offset line.
    push(K_ERR, 32'd0);
    send_line("O0000", t);
    send_byte(8'h30, 1'b0);
    idle(2 * CPB);
    send_line("\r", t);
    drain("ferr");
    push(K_OFS, 32'h00000010);
    send_line("O00000010\r", t);
    drain("ofs_10");

    // Short glitch on idle line is ignored.
    rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    idle(3 * CPB);
    push(K_SYNC, 32'd1);
    send_line("S1\r", t);
    drain("glitch_s1");
    chk("glitch_cnt", {24'b0, o_err_cnt}, 32'd4);

    // Error counter saturation.
    repeat (300) push(K_ERR, 32'd0);
    for (int i = 0; i < 300; i++) send_line("x\r", t);
    drain("sat");
    chk("sat_cnt", {24'b0, o_err_cnt}, 32'd255);

    // Reset during the data bits of the second byte.
    send_byte(8'h53);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b0);
    res_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("midrst");
    res_n = 1'b1;
    idle(2 * CPB);
    push(K_SYNC, 32'd1);
    send_line("S1\r", t);
    drain("post_rst");
    chk("post_rst_cnt", {24'b0, o_err_cnt}, 32'd0);
    chk("post_rst_ofs", o_pps_offset, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
